inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Instruction encoder: packs decoded RV32I fields (format, opcode, funct3/7, register indices, immediate) into a 32-bit instruction word.
- Each accepted instruction gets a sequential word address and is buffered in a small output FIFO.
- Used by the boot/test loader to fill instruction memory; the inverse of the core's immediate/field decode.
- Immediate conventions match the core decoder. U-type immediate is the 20-bit upper field, right-aligned (in_imm[19:0] -> inst[31:12]).

Parameters:
ADDR_W, 10, width of the word-address counter (wraps at 2^ADDR_W)
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J 6=I-shift 7=illegal
in_opcode  in  7  opcode, placed verbatim in inst[6:0]
in_funct3  in  3  inst[14:12] for R/I/S/B/I-shift
in_funct7  in  7  inst[31:25] for R/I-shift
in_rd, in_rs1, in_rs2  in  5 each  register indices
in_imm  in  32  immediate, two's complement (U: unsigned 20-bit)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pops head when out_valid && out_ready
out_inst  out  32  encoded instruction at head
out_addr  out  ADDR_W  word address at head
err_range  out  1  one-cycle pulse: last accepted request rejected
err_count  out  8  rejected-request count, saturates at 255

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, out_inst=0, out_addr=0, address counter=0, err_range=0, err_count=0, state=RUN.
- in_ready = (state==RUN) && (FIFO count < FIFO_DEPTH). Uses registered count only; a same-cycle pop does not free a slot for a same-cycle push.
- Field placement:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - I-shift: {funct7, imm[4:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[19:0], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range rules (violation = reject):
  - I, S: -2048..2047
  - B: -4096..4094, imm[0]=0
  - J: -1048576..1048574, imm[0]=0
  - U: in_imm[31:20]==0
  - I-shift: 0..31
  - R: imm ignored
  - fmt 7: always rejected
- Accept in cycle N:
  - Valid request: entry {inst, addr_cnt} written to FIFO at edge N. Address counter increments, wrapping 2^ADDR_W-1 -> 0. If FIFO was empty, out_valid=1 in cycle N+1.
  - Rejected request: no FIFO write, counter unchanged, err_range=1 during cycle N+1 only, err_count += 1 (saturating).
- Push and pop in the same cycle: both occur; count unchanged.
- out_inst and out_addr stay stable while out_valid && !out_ready.
- State machine: RUN only, unless the optional feature below is compiled in.

Optional Feature:
- Macro: INST_ENC_ERR_HALT_EN.
- Defined: adds state HALT. Any rejection moves RUN -> HALT at the same edge that raises err_range. In HALT, in_ready=0 permanently and the FIFO still drains normally. Exit only via rst_n.
- Undefined: rejection drops the request; operation continues in RUN.

Test Plan:
- I, opcode 0010011, f3=0, rd=1, rs1=0, imm=5 -> out_inst=0x00500093, out_addr=0, out_valid one cycle after accept.
- S opcode 0100011, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; then B opcode 1100011, f3=0, rs1=rs2=0, imm=-4 -> 0xFE000EE3, addr=1.
- J opcode 1101111, rd=1, imm=2048 -> 0x001000EF. U opcode 0110111, rd=5, imm=0x12345 -> 0x123452B7.
- I imm=2048, then B imm=3 -> two err_range pulses, err_count=2, no FIFO writes, next valid request still gets addr=0. With INST_ENC_ERR_HALT_EN: in_ready stays 0 after the first error.
- ADDR_W=2, out_ready=0, push 5 valid requests -> in_ready drops after the 4th. Then out_ready=1 -> addresses popped 0,1,2,3; 5th accepted gets addr=0 (wrap).
- rst_n asserted mid-stream with 3 entries buffered -> out_valid=0 immediately (async). After release, next request gets addr=0 and err_count=0.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Request/response bus of the RV32I instruction encoder.
// master: loader side that issues requests and drains the output FIFO.
// slave : the encoder itself.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              err_range;
    logic [7:0]        err_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err_range, err_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, err_range, err_count
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, tags it
// with a sequential word address and buffers it in a small output FIFO.
// Out-of-range immediates and illegal formats are rejected and counted.
// Optional macro INST_ENC_ERR_HALT_EN: the first rejection halts intake
// (state HALT) until rst_n; the FIFO keeps draining.
module inst_encoder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    inst_encoder_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;
    logic [31:0]       mem_inst_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];

    logic signed [31:0] imm_s;
    logic [31:0]        inst_d;
    logic               legal_d;
    logic               take;
    logic               push;
    logic               reject;
    logic               pop;

    assign imm_s        = signed'(bus.in_imm);
    assign bus.in_ready = (state_q == ST_RUN) && (cnt_q < CNT_W'(FIFO_DEPTH));
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_inst  = bus.out_valid ? mem_inst_q[rd_ptr_q] : '0;
    assign bus.out_addr  = bus.out_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign bus.err_range = err_q;
    assign bus.err_count = err_cnt_q;

    assign take   = bus.in_valid && bus.in_ready;
    assign push   = take && legal_d;
    assign reject = take && !legal_d;
    assign pop    = bus.out_valid && bus.out_ready;

    // Field placement and immediate range check for the requested format.
    always_comb begin
        inst_d  = '0;
        legal_d = 1'b1;
        case (bus.in_fmt)
            3'd0: inst_d = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
            3'd1: begin
                inst_d  = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                           bus.in_rd, bus.in_opcode};
                legal_d = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            3'd2: begin
                inst_d  = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           bus.in_imm[4:0], bus.in_opcode};
                legal_d = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            3'd3: begin
                inst_d  = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                           bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11],
                           bus.in_opcode};
                legal_d = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) &&
                          !bus.in_imm[0];
            end
            3'd4: begin
                inst_d  = {bus.in_imm[19:0], bus.in_rd, bus.in_opcode};
                legal_d = (bus.in_imm[31:20] == 12'd0);
            end
            3'd5: begin
                inst_d  = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                           bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
                legal_d = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) &&
                          !bus.in_imm[0];
            end
            3'd6: begin
                inst_d  = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                           bus.in_rd, bus.in_opcode};
                legal_d = (bus.in_imm[31:5] == 27'd0);
            end
            default: begin
                inst_d  = '0;
                legal_d = 1'b0;
            end
        endcase
    end

    // Control FSM with registered error pulse and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q <= reject;
            if (reject && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
`ifdef INST_ENC_ERR_HALT_EN
            if (reject) begin
                state_q <= ST_HALT;
            end
`else
            state_q <= ST_RUN;
`endif
        end
    end

    // FIFO pointers, occupancy and word-address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                addr_q   <= addr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until the matching count is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= inst_d;
            mem_addr_q[wr_ptr_q] <= addr_q;
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (ADDR_W=2, FIFO_DEPTH=4).
module tb_inst_encoder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(2)) bus ();

    inst_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_fmt    = '0;
        bus.in_opcode = '0;
        bus.in_funct3 = '0;
        bus.in_funct7 = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;
    endtask

    // Called and returns at a falling edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one request; returns at the falling edge after the accepting edge.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int n;
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Check the FIFO head and pop it; returns at a falling edge.
    task automatic pop_chk(input string tag, input logic [31:0] exp_inst, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_inst"}, bus.out_inst, exp_inst);
        chk({tag, "_addr"}, {30'd0, bus.out_addr}, exp_addr);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #1;
        // Reset state
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_addr", {30'd0, bus.out_addr}, 32'd0);
        chk("rst_err_range", {31'd0, bus.err_range}, 32'd0);
        chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // I-type: addi x1, x0, 5
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("i_out_valid", {31'd0, bus.out_valid}, 32'd1);
        pop_chk("i", 32'h00500093, 32'd0);
        chk("i_empty", {31'd0, bus.out_valid}, 32'd0);

        // S, B, J, U fill the FIFO (addresses 0..3)
        do_reset();
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stable_inst_a", bus.out_inst, 32'h0020A423);
        @(negedge clk);
        chk("stable_inst_b", bus.out_inst, 32'h0020A423);
        chk("stable_addr_b", {30'd0, bus.out_addr}, 32'd0);
        pop_chk("s", 32'h0020A423, 32'd0);
        pop_chk("b", 32'hFE000EE3, 32'd1);
        pop_chk("j", 32'h001000EF, 32'd2);
        pop_chk("u", 32'h123452B7, 32'd3);
        chk("fill_empty", {31'd0, bus.out_valid}, 32'd0);

        // R, I-shift, negative I; address counter has wrapped to 0
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF);
        send(3'd6, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
        pop_chk("r", 32'h002081B3, 32'd0);
        pop_chk("srai", 32'h40315093, 32'd1);
        pop_chk("i_neg", 32'hFFF00093, 32'd2);

        // Range errors
        do_reset();
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        chk("err1_pulse", {31'd0, bus.err_range}, 32'd1);
        chk("err1_count", {24'd0, bus.err_count}, 32'd1);
        chk("err1_no_write", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("err1_pulse_end", {31'd0, bus.err_range}, 32'd0);
`ifdef INST_ENC_ERR_HALT_EN
        chk("halt_in_ready_a", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("halt_in_ready_b", {31'd0, bus.in_ready}, 32'd0);
        chk("halt_count", {24'd0, bus.err_count}, 32'd1);
`else
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        chk("err2_pulse", {31'd0, bus.err_range}, 32'd1);
        chk("err2_count", {24'd0, bus.err_count}, 32'd2);
        chk("err2_no_write", {31'd0, bus.out_valid}, 32'd0);
        send(3'd6, 7'h13, 3'd1, 7'd0, 5'd1, 5'd0, 5'd0, 32'd32);
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        chk("err4_count", {24'd0, bus.err_count}, 32'd4);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
        chk("ok_after_err_pulse", {31'd0, bus.err_range}, 32'd0);
        pop_chk("ok_after_err", 32'h7FF00093, 32'd0);
`endif

        // Full FIFO, registered-count backpressure and address wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(3'd1, 7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
        end
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_fmt    = 3'd1;
        bus.in_opcode = 7'h13;
        bus.in_rd     = 5'd7;
        bus.in_imm    = 32'd100;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        chk("bp_held_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("wrap_addr0", {30'd0, bus.out_addr}, 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
        chk("wrap_addr1", {30'd0, bus.out_addr}, 32'd1);
        chk("wrap_inst1", bus.out_inst, 32'h00100113);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pushpop_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("wrap_addr2", {30'd0, bus.out_addr}, 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_addr3", {30'd0, bus.out_addr}, 32'd3);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_addr5", {30'd0, bus.out_addr}, 32'd0);
        chk("wrap_inst5", bus.out_inst, 32'h06400393);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("wrap_empty", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'(i + 1));
        end
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        chk("pre_rst_count", {24'd0, bus.err_count}, 32'd1);
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_err_count", {24'd0, bus.err_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("post_rst_err_count", {24'd0, bus.err_count}, 32'd0);
        pop_chk("post_rst", 32'h00500093, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
